fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits[1:0] SHALL be 0.
REQ-002 Parameter BUF_DEPTH, default 2: instruction buffer entries; legal values 2 and 4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 redirect_valid  input  1  taken branch/jump from execute.
REQ-006 redirect_pc  input  32  new fetch address.
REQ-007 imem_req_valid  output  1  instruction-memory read request.
REQ-008 imem_req_addr  output  32  request address, word aligned.
REQ-009 imem_req_ready  input  1  memory accepts the request.
REQ-010 imem_rsp_valid  input  1  read data returned; responses arrive in request order, at least 1 cycle after acceptance.
REQ-011 imem_rsp_data  input  32  returned instruction word.
REQ-012 inst_valid  output  1  buffer head holds an instruction for decode.
REQ-013 inst_data  output  32  head instruction word.
REQ-014 inst_pc  output  32  address of head instruction.
REQ-015 inst_ready  input  1  decode consumes the head this cycle.

Function
REQ-016 Request accept = imem_req_valid & imem_req_ready; consume = inst_valid & inst_ready.
REQ-017 fetch_pc increments by 4 on each accepted request; modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
REQ-018 imem_req_valid SHALL be asserted in FETCH only when occupancy + outstanding < BUF_DEPTH.
REQ-019 Once asserted, imem_req_valid and imem_req_addr SHALL hold until accepted, except in a redirect cycle.
REQ-020 Each non-stale response is written to the buffer tail with its PC; inst_valid rises the cycle after imem_rsp_valid (1-cycle latency).
REQ-021 The buffer is FIFO; simultaneous write and consume at full occupancy SHALL be legal.
REQ-022 FSM states: FETCH and FLUSH.
REQ-023 On redirect_valid in any state, the FSM SHALL:
  - clear the buffer;
  - load fetch_pc with {redirect_pc[31:2],2'b00};
  - set drop_cnt to outstanding minus any response in that cycle;
  - enter FLUSH if drop_cnt is nonzero, otherwise FETCH.
REQ-024 A consume in the same cycle as a redirect SHALL complete normally; the remaining entries are discarded.
REQ-025 A request accepted in a redirect cycle counts as stale, and the next request carries the redirect address.
REQ-026 In FLUSH, no requests are issued; each response decrements drop_cnt and is discarded; FETCH is entered the cycle after drop_cnt reaches 0.
REQ-027 In a redirect cycle, a response is always treated as stale.
REQ-028 inst_valid SHALL be 0 while the buffer is empty, including the cycle after a redirect.
REQ-029 When inst_valid is 0, inst_data and inst_pc are don't-care.

Reset
REQ-030 While rst_n is 0, the block SHALL hold these values:
  - imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0;
  - buffer empty, outstanding=0, drop_cnt=0;
  - fetch_pc=RESET_PC, state=FETCH.
REQ-031 The first request (addr RESET_PC) SHALL be asserted in the first cycle after rst_n rises.
REQ-032 Reset mid-operation SHALL discard all buffered and outstanding work; the memory is reset by the same rst_n.

Configuration
REQ-033 With FETCH_MISALIGN_CHK_EN defined:
  - output port misalign_err (1 bit) exists;
  - a redirect with redirect_pc[1:0]!=0 is ignored and sets misalign_err sticky until reset.
REQ-034 Without FETCH_MISALIGN_CHK_EN, the port is absent and redirect_pc[1:0] is cleared as in REQ-023.

Verification
REQ-035 Reset release; memory ready=1 with 1-cycle response; inst_ready=1 -> inst_pc sequence 0,4,8,12 with matching data, one instruction per cycle after fill.
REQ-036 inst_ready=0 for 10 cycles -> exactly BUF_DEPTH requests issued, then req_valid stays 0; buffer contents unchanged.
REQ-037 Two requests outstanding (addr 8,12), redirect_pc=32'h100 -> both responses dropped; next inst_pc=32'h100.
REQ-038 fetch_pc=32'hFFFF_FFFC -> following request addr 32'h0.
REQ-039 imem_req_ready=0 for 3 cycles -> req_addr stable; redirect in cycle 2 changes addr to redirect target.
REQ-040 With FETCH_MISALIGN_CHK_EN, redirect_pc=32'h102 -> misalign_err=1, fetch continues sequentially; without it, fetch resumes at 32'h100.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC generation, in-order memory requests and a small FIFO
// toward decode, with redirect/flush handling. Optional FETCH_MISALIGN_CHK_EN adds misalign_err.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        misalign_err
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  typedef enum logic {FETCH, FLUSH} state_t;

  state_t         state, state_next;
  logic [31:0]    fetch_pc, rsp_pc;
  logic [31:0]    buf_data [BUF_DEPTH];
  logic [31:0]    buf_pc   [BUF_DEPTH];
  logic [PW-1:0]  head, tail;
  logic [CW-1:0]  count, outstanding, drop_cnt;
  logic [CW-1:0]  out_next, drop_next;
  logic           accept, consume, write, redirect_take;
  logic [31:0]    redirect_addr;

  assign redirect_addr = redirect_pc & ~32'h3;
`ifdef FETCH_MISALIGN_CHK_EN
  assign redirect_take = redirect_valid & (redirect_pc[1:0] == 2'b00);
`else
  assign redirect_take = redirect_valid;
`endif

  // Occupancy plus in-flight requests never exceeds the buffer, so every response has a slot.
  assign imem_req_valid = rst_n & (state == FETCH) &
                          (({1'b0, count} + {1'b0, outstanding}) < SW'(BUF_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid & imem_req_ready;
  assign consume        = inst_valid & inst_ready;
  assign write          = imem_rsp_valid & ~redirect_take & (state == FETCH);
  assign out_next       = outstanding + CW'(accept) - CW'(imem_rsp_valid);

  assign inst_valid = (count != '0);
  assign inst_data  = buf_data[head];
  assign inst_pc    = buf_pc[head];

  always_comb begin
    state_next = state;
    drop_next  = drop_cnt;
    if (redirect_take) begin
      drop_next  = out_next;
      state_next = (out_next != '0) ? FLUSH : FETCH;
    end else if (state == FLUSH && imem_rsp_valid) begin
      if (drop_cnt != '0) drop_next = drop_cnt - CW'(1);
      if (drop_cnt <= CW'(1)) state_next = FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_data[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else begin
      state       <= state_next;
      drop_cnt    <= drop_next;
      outstanding <= out_next;
      if (redirect_take) begin
        fetch_pc <= redirect_addr;
        rsp_pc   <= redirect_addr;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        // rsp_pc tracks the address of the next non-stale response, since memory answers in order.
        if (write) begin
          buf_data[tail] <= imem_rsp_data;
          buf_pc[tail]   <= rsp_pc;
          tail           <= tail + PW'(1);
          rsp_pc         <= rsp_pc + 32'd4;
        end
        if (consume) head <= head + PW'(1);
        count <= count + CW'(write) - CW'(consume);
      end
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      misalign_err <= 1'b0;
    else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
      misalign_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model, scoreboard of expected decode
// instructions, a redirect vector table and hand-written flush/stall/misalign sequences.
module tb_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk, rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data, inst_pc;
  logic        inst_ready;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_err;
`endif

  fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
`ifdef FETCH_MISALIGN_CHK_EN
    , .misalign_err(misalign_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] target;
    logic [31:0] e0, e1, e2;
  } redir_vec_t;

  int          n_cmp, n_fail, n_cons, n_acc, cyc, rsp_budget;
  logic [31:0] pend_q[$];
  logic [31:0] exp_q[$];
  int          cons_cyc[$];
  redir_vec_t  vecs[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample at negedge, let the edge happen, then play the memory for the next cycle.
  task automatic apply_cycle();
    logic        acc, con;
    logic [31:0] addr, e;
    @(negedge clk);
    acc  = imem_req_valid && imem_req_ready;
    addr = imem_req_addr;
    con  = inst_valid && inst_ready;
    if (con) begin
      n_cons++;
      cons_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_inst: got pc %h expected none", inst_pc);
      end else begin
        e = exp_q.pop_front();
        check_output("inst_pc", inst_pc, e);
        check_output("inst_data", inst_data, mem_word(e));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      pend_q.push_back(addr);
      n_acc++;
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (rsp_budget > 0 && pend_q.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_q.pop_front());
      rsp_budget--;
    end
  endtask

  task automatic apply_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    apply_cycle();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  task automatic wait_cons(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (n_cons < target && k < budget) begin
      apply_cycle();
      k++;
    end
    if (n_cons < target) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s_timeout: got %0d consumed expected %0d", name, n_cons, target);
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    rsp_budget     = 1000;
    pend_q.delete();
    exp_q.delete();
    @(negedge clk);
    check_output("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_output("rst_inst_valid", 32'(inst_valid), 32'd0);
    check_output("rst_inst_data", inst_data, 32'd0);
    check_output("rst_inst_pc", inst_pc, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_cons = 0;
    n_acc  = 0;
    cyc    = 0;
    cons_cyc.delete();
    #2;
    check_output("first_req_valid", 32'(imem_req_valid), 32'd1);
    check_output("first_req_addr", imem_req_addr, RST_PC);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    inst_ready = 1'b0;

    vecs.push_back('{32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108});
    vecs.push_back('{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000});
    vecs.push_back('{32'h8000_0040, 32'h8000_0040, 32'h8000_0044, 32'h8000_0048});
`ifndef FETCH_MISALIGN_CHK_EN
    vecs.push_back('{32'h0000_1003, 32'h0000_1000, 32'h0000_1004, 32'h0000_1008});
`endif

    // Streaming: one instruction per cycle once the pipe is full.
    do_reset();
    inst_ready = 1'b1;
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    wait_cons(4, 30, "stream");
    inst_ready = 1'b0;
    if (cons_cyc.size() >= 4) begin
      check_output("first_inst_cycle", 32'(cons_cyc[0]), 32'd2);
      for (int i = 1; i < 4; i++)
        check_output("stream_gap", 32'(cons_cyc[i] - cons_cyc[i-1]), 32'd1);
    end

    // Decode stalled: only DEPTH requests, head held.
    do_reset();
    repeat (10) apply_cycle();
    check_output("stall_req_count", 32'(n_acc), 32'(DEPTH));
    check_output("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check_output("stall_inst_valid", 32'(inst_valid), 32'd1);
    check_output("stall_inst_pc", inst_pc, RST_PC);
    check_output("stall_inst_data", inst_data, mem_word(RST_PC));

    // Redirect table, each applied with a full buffer; reset here lands mid-operation.
    do_reset();
    foreach (vecs[v]) begin
      inst_ready = 1'b0;
      repeat (6) apply_cycle();
      exp_q.delete();
      apply_redirect(vecs[v].target);
      check_output("post_redirect_inst_valid", 32'(inst_valid), 32'd0);
      exp_q.push_back(vecs[v].e0);
      exp_q.push_back(vecs[v].e1);
      exp_q.push_back(vecs[v].e2);
      inst_ready = 1'b1;
      wait_cons(n_cons + 3, 40, "redirect_vec");
      inst_ready = 1'b0;
    end

    // Redirect with addresses 8 and 12 still outstanding: both responses must be dropped.
    do_reset();
    rsp_budget = 0;
    for (int k = 0; k < 10 && n_acc < 4; k++) apply_cycle();
    rsp_budget = 2;
    repeat (3) apply_cycle();
    check_output("flush_pending", 32'(pend_q.size()), 32'd2);
    if (pend_q.size() == 2) begin
      check_output("flush_pend0", pend_q[0], 32'h8);
      check_output("flush_pend1", pend_q[1], 32'hC);
    end
    rsp_budget = 0;
    apply_redirect(32'h100);
    check_output("flush_req_valid", 32'(imem_req_valid), 32'd0);
    exp_q = '{32'h100, 32'h104};
    rsp_budget = 1000;
    inst_ready = 1'b1;
    wait_cons(n_cons + 2, 40, "flush");
    inst_ready = 1'b0;

    // Memory not ready: request held, redirect in the second cycle retargets it.
    do_reset();
    imem_req_ready = 1'b0;
    check_output("hold_c0_addr", imem_req_addr, RST_PC);
    apply_cycle();
    check_output("hold_c1_valid", 32'(imem_req_valid), 32'd1);
    check_output("hold_c1_addr", imem_req_addr, RST_PC);
    apply_redirect(32'h340);
    check_output("hold_redirect_valid", 32'(imem_req_valid), 32'd1);
    check_output("hold_redirect_addr", imem_req_addr, 32'h340);
    check_output("hold_acc_count", 32'(n_acc), 32'd0);
    imem_req_ready = 1'b1;
    exp_q = '{32'h340, 32'h344};
    inst_ready = 1'b1;
    wait_cons(n_cons + 2, 40, "hold");
    inst_ready = 1'b0;

    // Misaligned redirect target.
    do_reset();
    repeat (8) apply_cycle();
`ifdef FETCH_MISALIGN_CHK_EN
    check_output("misalign_before", 32'(misalign_err), 32'd0);
    apply_redirect(32'h102);
    check_output("misalign_after", 32'(misalign_err), 32'd1);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    inst_ready = 1'b1;
    wait_cons(n_cons + 5, 40, "misalign");
`else
    apply_redirect(32'h102);
    check_output("misalign_inst_valid", 32'(inst_valid), 32'd0);
    exp_q = '{32'h100, 32'h104};
    inst_ready = 1'b1;
    wait_cons(n_cons + 2, 40, "misalign");
`endif
    inst_ready = 1'b0;
    repeat (2) apply_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
